// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck core and its data-side bridge.
package bf_pkg;

  // Byte width carried by the I/O streams.
  localparam int BYTE_W = 8;

  // Encoding of the core's data_w_sel / data_r_sel target bits.
  localparam logic SEL_MEM = 1'b0;
  localparam logic SEL_IO  = 1'b1;

  // Command encoding used by the core's decoder.
  typedef enum logic [2:0] {
    OP_INC  = 3'd0,  // +
    OP_DEC  = 3'd1,  // -
    OP_NEXT = 3'd2,  // >
    OP_PREV = 3'd3,  // <
    OP_OUT  = 3'd4,  // .
    OP_IN   = 3'd5,  // ,
    OP_JZ   = 3'd6,  // [
    OP_JNZ  = 3'd7   // ]
  } bf_op_e;

  // Source of the read data returned to the core one cycle after a request.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_MEM  = 2'd1,
    RD_RX   = 2'd2
  } rd_src_e;

endpackage

// File: rtl/bf_sync_fifo.sv
// Single-clock FIFO with registered head output. A push into a full FIFO is
// accepted when a pop happens in the same cycle; pops on an empty FIFO and
// pushes that cannot be accepted are ignored (the caller flags them).
module bf_sync_fifo #(
  parameter int WIDTH       = 8,
  parameter int FDEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [FDEPTH_LOG2:0]   count
);

  localparam int                     DEPTH    = 1 << FDEPTH_LOG2;
  localparam logic [FDEPTH_LOG2:0]   CNT_FULL = {1'b1, {FDEPTH_LOG2{1'b0}}};
  localparam logic [FDEPTH_LOG2:0]   CNT_ZERO = {(FDEPTH_LOG2+1){1'b0}};
  localparam logic [FDEPTH_LOG2:0]   CNT_ONE  = (FDEPTH_LOG2+1)'(1);
  localparam logic [FDEPTH_LOG2-1:0] PTR_ZERO = {FDEPTH_LOG2{1'b0}};
  localparam logic [FDEPTH_LOG2-1:0] PTR_ONE  = FDEPTH_LOG2'(1);

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [FDEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FDEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FDEPTH_LOG2:0]   count_q, count_d;
  logic                   do_push_s, do_pop_s;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == CNT_ZERO);
  assign count     = count_q;
  assign dout      = mem_q[rd_ptr_q];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; both resets discard the contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else if (s_rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/bf_data_io.sv
// Data-side bridge behind the brainfuck core: routes memory requests to the
// data SRAM, "." writes into a TX byte FIFO and "," reads out of an RX FIFO,
// returning read data one cycle after the request.
module bf_data_io
  import bf_pkg::*;
#(
  parameter int AWIDTH      = 12,
  parameter int DWIDTH      = 16,
  parameter int FDEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_rst,
  input  logic [AWIDTH-1:0] dp_adr,
  input  logic [DWIDTH-1:0] data_out,
  input  logic              data_w_req,
  input  logic              data_w_sel,
  input  logic              data_r_req,
  input  logic              data_r_sel,
  output logic [DWIDTH-1:0] data_in,
  output logic              data_den,
  output logic              data_w_wait,
  output logic [AWIDTH-1:0] mem_adr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              tx_ovf,
  output logic              rx_empty_rd
);

  logic                  tx_push_s, tx_pop_s, tx_full_s, tx_empty_s, tx_drop_s;
  logic [BYTE_W-1:0]     tx_dout_s;
  logic [FDEPTH_LOG2:0]  tx_count_unused_s;
  logic                  rx_push_s, rx_rd_s, rx_pop_s, rx_full_s, rx_empty_s;
  logic [BYTE_W-1:0]     rx_dout_s;
  logic [FDEPTH_LOG2:0]  rx_count_unused_s;
  logic                  mem_rd_s;
  rd_src_e               rd_src_q, rd_src_d;
  logic [BYTE_W-1:0]     rx_byte_q, rx_byte_d;
  logic                  tx_ovf_q, rx_empty_rd_q;

  // Memory path is a straight pass-through, including the core's clear phase.
  assign mem_adr   = dp_adr;
  assign mem_wdata = data_out;
  assign mem_we    = data_w_req & (data_w_sel == SEL_MEM);
  assign mem_rd_s  = data_r_req & (data_r_sel == SEL_MEM);
  assign mem_re    = mem_rd_s;

  // TX: a push into a full FIFO survives only if the consumer pops this cycle.
  assign tx_push_s   = data_w_req & (data_w_sel == SEL_IO);
  assign tx_pop_s    = ~tx_empty_s & tx_ready;
  assign tx_drop_s   = tx_push_s & tx_full_s & ~tx_pop_s;
  assign tx_valid    = ~tx_empty_s;
  assign tx_data     = tx_dout_s;
  assign data_w_wait = tx_full_s;

  // RX: the pop decision uses pre-edge occupancy, so there is no bypass.
  assign rx_ready  = ~rx_full_s;
  assign rx_push_s = rx_valid & ~rx_full_s;
  assign rx_rd_s   = data_r_req & (data_r_sel == SEL_IO);
  assign rx_pop_s  = rx_rd_s & ~rx_empty_s;

  assign tx_ovf      = tx_ovf_q;
  assign rx_empty_rd = rx_empty_rd_q;
  assign data_den    = (rd_src_q != RD_NONE);

  bf_sync_fifo #(.WIDTH(BYTE_W), .FDEPTH_LOG2(FDEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .s_rst (s_rst),
    .push  (tx_push_s),
    .pop   (tx_pop_s),
    .din   (data_out[BYTE_W-1:0]),
    .dout  (tx_dout_s),
    .full  (tx_full_s),
    .empty (tx_empty_s),
    .count (tx_count_unused_s)
  );

  bf_sync_fifo #(.WIDTH(BYTE_W), .FDEPTH_LOG2(FDEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .s_rst (s_rst),
    .push  (rx_push_s),
    .pop   (rx_pop_s),
    .din   (rx_data),
    .dout  (rx_dout_s),
    .full  (rx_full_s),
    .empty (rx_empty_s),
    .count (rx_count_unused_s)
  );

  // Select which source answers next cycle and capture the popped RX byte.
  always_comb begin
    rd_src_d  = RD_NONE;
    rx_byte_d = rx_byte_q;
    if (mem_rd_s) begin
      rd_src_d = RD_MEM;
    end else if (rx_pop_s) begin
      rd_src_d = RD_RX;
    end else begin
      rd_src_d = RD_NONE;
    end
    if (rx_pop_s) begin
      rx_byte_d = rx_dout_s;
    end else begin
      rx_byte_d = rx_byte_q;
    end
  end

  // Read-return state and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_src_q      <= RD_NONE;
      rx_byte_q     <= {BYTE_W{1'b0}};
      tx_ovf_q      <= 1'b0;
      rx_empty_rd_q <= 1'b0;
    end else if (s_rst) begin
      rd_src_q      <= RD_NONE;
      rx_byte_q     <= {BYTE_W{1'b0}};
      tx_ovf_q      <= 1'b0;
      rx_empty_rd_q <= 1'b0;
    end else begin
      rd_src_q      <= rd_src_d;
      rx_byte_q     <= rx_byte_d;
      tx_ovf_q      <= tx_ovf_q | tx_drop_s;
      rx_empty_rd_q <= rx_empty_rd_q | (rx_rd_s & rx_empty_s);
    end
  end

  // Read data mux on the registered source; SRAM data arrives this cycle.
  always_comb begin
    data_in = {DWIDTH{1'b0}};
    case (rd_src_q)
      RD_MEM:  data_in = mem_rdata;
      RD_RX:   data_in = {{(DWIDTH-BYTE_W){1'b0}}, rx_byte_q};
      default: data_in = {DWIDTH{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_bf_data_io.sv
// Directed self-checking bench for bf_data_io.
module tb_bf_data_io;

  logic        clk = 1'b0;
  logic        rst, s_rst;
  logic [11:0] dp_adr;
  logic [15:0] data_out;
  logic        data_w_req, data_w_sel, data_r_req, data_r_sel;
  logic [15:0] data_in;
  logic        data_den, data_w_wait;
  logic [11:0] mem_adr;
  logic [15:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [15:0] mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic        tx_ovf, rx_empty_rd;

  int checks = 0;
  int failures = 0;

  bf_data_io dut (
    .clk(clk), .rst(rst), .s_rst(s_rst), .dp_adr(dp_adr), .data_out(data_out),
    .data_w_req(data_w_req), .data_w_sel(data_w_sel),
    .data_r_req(data_r_req), .data_r_sel(data_r_sel),
    .data_in(data_in), .data_den(data_den), .data_w_wait(data_w_wait),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_ovf(tx_ovf), .rx_empty_rd(rx_empty_rd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are changed here.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes before sampling.
  task automatic settle();
    #1;
  endtask

  logic [7:0] exp_tx [16];

  initial begin
    rst = 1'b1; s_rst = 1'b0; dp_adr = 12'h000; data_out = 16'h0000;
    data_w_req = 1'b0; data_w_sel = 1'b0; data_r_req = 1'b0; data_r_sel = 1'b0;
    mem_rdata = 16'h0000; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) next_cyc();
    rst = 1'b0;
    settle();
    check_eq("rst_den", {31'd0, data_den}, 32'd0);
    check_eq("rst_din", {16'd0, data_in}, 32'd0);
    check_eq("rst_txv", {31'd0, tx_valid}, 32'd0);
    check_eq("rst_rxr", {31'd0, rx_ready}, 32'd1);
    check_eq("rst_wait", {31'd0, data_w_wait}, 32'd0);
    check_eq("rst_ovf", {31'd0, tx_ovf}, 32'd0);
    check_eq("rst_erd", {31'd0, rx_empty_rd}, 32'd0);

    // 1: memory read with one-cycle return
    next_cyc();
    dp_adr = 12'h005; data_r_req = 1'b1; data_r_sel = 1'b0;
    settle();
    check_eq("t1_re", {31'd0, mem_re}, 32'd1);
    check_eq("t1_adr", {20'd0, mem_adr}, 32'h5);
    check_eq("t1_we", {31'd0, mem_we}, 32'd0);
    next_cyc();
    data_r_req = 1'b0; mem_rdata = 16'h0042;
    settle();
    check_eq("t1_din", {16'd0, data_in}, 32'h0042);
    check_eq("t1_den", {31'd0, data_den}, 32'd1);
    next_cyc();
    settle();
    check_eq("t1_idle_den", {31'd0, data_den}, 32'd0);
    check_eq("t1_idle_din", {16'd0, data_in}, 32'd0);

    // 2: three "." writes held by tx_ready=0, then drained in order
    data_w_req = 1'b1; data_w_sel = 1'b1;
    data_out = 16'h0141; settle(); check_eq("t2_we0", {31'd0, mem_we}, 32'd0); next_cyc();
    data_out = 16'h0042; settle(); check_eq("t2_we1", {31'd0, mem_we}, 32'd0); next_cyc();
    data_out = 16'h0043; settle(); check_eq("t2_we2", {31'd0, mem_we}, 32'd0); next_cyc();
    data_w_req = 1'b0; data_w_sel = 1'b0;
    settle();
    check_eq("t2_hold_txd", {24'd0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    exp_tx[0] = 8'h41; exp_tx[1] = 8'h42; exp_tx[2] = 8'h43;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("t2_txv", {31'd0, tx_valid}, 32'd1);
      check_eq("t2_txd", {24'd0, tx_data}, {24'd0, exp_tx[i]});
      next_cyc();
    end
    settle();
    check_eq("t2_txv_end", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // 3: two bytes in RX, three "," reads
    rx_valid = 1'b1; rx_data = 8'h31; next_cyc();
    rx_data = 8'h32; next_cyc();
    rx_valid = 1'b0;
    data_r_req = 1'b1; data_r_sel = 1'b1;
    next_cyc();
    settle();
    check_eq("t3_din0", {16'd0, data_in}, 32'h0031);
    check_eq("t3_den0", {31'd0, data_den}, 32'd1);
    next_cyc();
    settle();
    check_eq("t3_din1", {16'd0, data_in}, 32'h0032);
    check_eq("t3_den1", {31'd0, data_den}, 32'd1);
    check_eq("t3_erd_pre", {31'd0, rx_empty_rd}, 32'd0);
    next_cyc();
    data_r_req = 1'b0; data_r_sel = 1'b0;
    settle();
    check_eq("t3_den2", {31'd0, data_den}, 32'd0);
    check_eq("t3_din2", {16'd0, data_in}, 32'd0);
    check_eq("t3_erd", {31'd0, rx_empty_rd}, 32'd1);

    // 4: fill TX, drop the 17th, accept a push during a pop
    data_w_req = 1'b1; data_w_sel = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_out = 16'h0200 + 16'(i);
      next_cyc();
      if (i == 14) begin
        settle();
        check_eq("t4_wait15", {31'd0, data_w_wait}, 32'd0);
      end
    end
    settle();
    check_eq("t4_wait", {31'd0, data_w_wait}, 32'd1);
    check_eq("t4_ovf_pre", {31'd0, tx_ovf}, 32'd0);
    data_out = 16'h00AA;
    next_cyc();
    settle();
    check_eq("t4_ovf", {31'd0, tx_ovf}, 32'd1);
    data_out = 16'h00BB; tx_ready = 1'b1;
    next_cyc();
    data_w_req = 1'b0; data_w_sel = 1'b0; tx_ready = 1'b0;
    settle();
    check_eq("t4_wait_after", {31'd0, data_w_wait}, 32'd1);
    for (int i = 0; i < 15; i++) exp_tx[i] = 8'(i + 1);
    exp_tx[15] = 8'hBB;
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      settle();
      check_eq("t4_drain", {24'd0, tx_data}, {24'd0, exp_tx[i]});
      next_cyc();
    end
    settle();
    check_eq("t4_empty", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // 5: fill RX, back-pressure, one read frees a slot
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'h50 + 8'(i);
      next_cyc();
    end
    rx_data = 8'h77;
    settle();
    check_eq("t5_rxr_full", {31'd0, rx_ready}, 32'd0);
    data_r_req = 1'b1; data_r_sel = 1'b1;
    next_cyc();
    data_r_req = 1'b0; data_r_sel = 1'b0;
    settle();
    check_eq("t5_din", {16'd0, data_in}, 32'h0050);
    check_eq("t5_den", {31'd0, data_den}, 32'd1);
    check_eq("t5_rxr", {31'd0, rx_ready}, 32'd1);
    check_eq("t5_erd_sticky", {31'd0, rx_empty_rd}, 32'd1);
    rx_valid = 1'b0;

    // 6: soft reset with TX data queued and a read issued alongside
    data_w_req = 1'b1; data_w_sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_out = 16'h0010 + 16'(i);
      next_cyc();
    end
    data_w_req = 1'b0; data_w_sel = 1'b0;
    settle();
    check_eq("t6_txv_pre", {31'd0, tx_valid}, 32'd1);
    s_rst = 1'b1; data_r_req = 1'b1; data_r_sel = 1'b0; mem_rdata = 16'h1234;
    next_cyc();
    s_rst = 1'b0; data_r_req = 1'b0;
    settle();
    check_eq("t6_txv", {31'd0, tx_valid}, 32'd0);
    check_eq("t6_den", {31'd0, data_den}, 32'd0);
    check_eq("t6_din", {16'd0, data_in}, 32'd0);
    check_eq("t6_ovf", {31'd0, tx_ovf}, 32'd0);
    check_eq("t6_erd", {31'd0, rx_empty_rd}, 32'd0);
    check_eq("t6_rxr", {31'd0, rx_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
